// File: rtl/alu_share_ctrl_if.sv
// rtl/alu_share_ctrl_if.sv - bundle of requester, ALU-side and response signals for alu_share_ctrl
interface alu_share_ctrl_if;
    // requester 0
    logic       req0_valid;
    logic       req0_ready;
    logic [5:0] req0_a;
    logic [5:0] req0_b;
    logic [3:0] req0_op;
    logic       req0_cin;
    // requester 1
    logic       req1_valid;
    logic       req1_ready;
    logic [5:0] req1_a;
    logic [5:0] req1_b;
    logic [3:0] req1_op;
    logic       req1_cin;
    // shared ALU
    logic [5:0] alu_a;
    logic [5:0] alu_b;
    logic [3:0] alu_op;
    logic       alu_cin;
    logic [5:0] alu_result;
    logic       alu_carry_out;
    // tagged response channel and status
    logic       rsp_valid;
    logic       rsp_ready;
    logic       rsp_id;
    logic [5:0] rsp_result;
    logic       rsp_carry;
    logic       rsp_err;
    logic       busy;
    logic [7:0] ops_done;

    // environment side: clients, ALU and response consumer
    modport master (
        output req0_valid, req0_a, req0_b, req0_op, req0_cin,
        output req1_valid, req1_a, req1_b, req1_op, req1_cin,
        output alu_result, alu_carry_out, rsp_ready,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op, alu_cin,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err, busy, ops_done
    );

    // controller side
    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op, req0_cin,
        input  req1_valid, req1_a, req1_b, req1_op, req1_cin,
        input  alu_result, alu_carry_out, rsp_ready,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op, alu_cin,
        output rsp_valid, rsp_id, rsp_result, rsp_carry, rsp_err, busy, ops_done
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// rtl/alu_share_ctrl.sv - round-robin sharing of one six_bit_ALU between two requesters
module alu_share_ctrl (
    input  logic             clk,
    input  logic             reset,
    alu_share_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_NOR = 4'b1100;

    state_t     state;
    state_t     state_nxt;

    // operand registers: the only source of the ALU inputs
    logic [5:0] opnd_a;
    logic [5:0] opnd_b;
    logic [3:0] opnd_op;
    logic       opnd_cin;
    logic       opnd_id;
    logic       last_id;

    // response registers
    logic [5:0] res_q;
    logic       carry_q;
    logic       err_q;
    logic [7:0] ops_cnt;

    logic       grant_valid;
    logic       grant_id;
    logic       ready0;
    logic       ready1;
    logic       accept;
    logic       rsp_fire;
    logic       op_legal;

    // Arbitration: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant_valid = bus.req0_valid | bus.req1_valid;
        grant_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant_id = ~last_id;
        end else if (bus.req1_valid) begin
            grant_id = 1'b1;
        end
    end

    assign ready0   = (state == IDLE) && grant_valid && !grant_id && !reset;
    assign ready1   = (state == IDLE) && grant_valid &&  grant_id && !reset;
    // ready is only raised toward a valid requester, so ready alone marks the handshake
    assign accept   = ready0 | ready1;
    assign rsp_fire = (state == RESP) && bus.rsp_ready;

    // Opcode decode: anything outside the five supported ops is reported as an error.
    always_comb begin
        op_legal = 1'b0;
        case (opnd_op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR: op_legal = 1'b1;
            default:                               op_legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept in IDLE, one ALU cycle in EXEC, hold RESP until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)   state_nxt = EXEC;
            EXEC:                  state_nxt = RESP;
            RESP:    if (rsp_fire) state_nxt = IDLE;
            default:               state_nxt = IDLE;
        endcase
    end

    // Operand capture on the request handshake; last_id remembers who was served.
    always_ff @(posedge clk) begin
        if (reset) begin
            opnd_a   <= 6'd0;
            opnd_b   <= 6'd0;
            opnd_op  <= 4'd0;
            opnd_cin <= 1'b0;
            opnd_id  <= 1'b0;
            last_id  <= 1'b1;
        end else if (accept) begin
            opnd_a   <= grant_id ? bus.req1_a   : bus.req0_a;
            opnd_b   <= grant_id ? bus.req1_b   : bus.req0_b;
            opnd_op  <= grant_id ? bus.req1_op  : bus.req0_op;
            opnd_cin <= grant_id ? bus.req1_cin : bus.req0_cin;
            opnd_id  <= grant_id;
            last_id  <= grant_id;
        end
    end

    // Response capture at the end of EXEC; illegal ops return zero data with err set.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q   <= 6'd0;
            carry_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (state == EXEC) begin
            res_q   <= op_legal ? bus.alu_result    : 6'd0;
            carry_q <= op_legal ? bus.alu_carry_out : 1'b0;
            err_q   <= !op_legal;
        end
    end

    // Completed-response counter, wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (reset) begin
            ops_cnt <= 8'd0;
        end else if (rsp_fire) begin
            ops_cnt <= ops_cnt + 8'd1;
        end
    end

    // SUB needs a borrow-free two's-complement add, so carry-in is forced high for it.
    assign bus.alu_a      = opnd_a;
    assign bus.alu_b      = opnd_b;
    assign bus.alu_op     = opnd_op;
    assign bus.alu_cin    = (opnd_op == OP_SUB) ? 1'b1 : opnd_cin;

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;

    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = opnd_id;
    assign bus.rsp_result = res_q;
    assign bus.rsp_carry  = carry_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = (state != IDLE);
    assign bus.ops_done   = ops_cnt;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// tb/tb_alu_share_ctrl.sv - scoreboard bench for alu_share_ctrl with a behavioural six_bit_ALU
module tb_alu_share_ctrl;

    logic clk;
    logic reset;

    alu_share_ctrl_if bus ();

    alu_share_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural ALU; unknown opcodes give nonzero junk so the error path is visible
    logic [6:0] alu_sum;
    always_comb begin
        alu_sum = 7'd0;
        case (bus.alu_op)
            4'b0000: alu_sum = {1'b0, bus.alu_a & bus.alu_b};
            4'b0001: alu_sum = {1'b0, bus.alu_a | bus.alu_b};
            4'b0010: alu_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {6'd0, bus.alu_cin};
            4'b0110: alu_sum = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {6'd0, bus.alu_cin};
            4'b1100: alu_sum = {1'b0, ~(bus.alu_a | bus.alu_b)};
            default: alu_sum = {1'b1, bus.alu_a ^ bus.alu_b};
        endcase
    end
    assign bus.alu_result    = alu_sum[5:0];
    assign bus.alu_carry_out = alu_sum[6];

    typedef struct {
        logic       id;
        logic [5:0] res;
        logic       carry;
        logic       err;
    } exp_t;

    exp_t sb[$];
    bit   grant_log[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // monitor: pops the scoreboard on every response handshake
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!reset && bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    fail_now("rsp_unexpected");
                end else begin
                    e = sb.pop_front();
                    chk("rsp_id",     bus.rsp_id,     e.id);
                    chk("rsp_result", bus.rsp_result, e.res);
                    chk("rsp_carry",  bus.rsp_carry,  e.carry);
                    chk("rsp_err",    bus.rsp_err,    e.err);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    task automatic chk_reset_outputs();
        chk("rst_req0_ready", bus.req0_ready, 0);
        chk("rst_req1_ready", bus.req1_ready, 0);
        chk("rst_rsp_valid",  bus.rsp_valid,  0);
        chk("rst_busy",       bus.busy,       0);
        chk("rst_ops_done",   bus.ops_done,   0);
        chk("rst_alu_a",      bus.alu_a,      0);
        chk("rst_alu_b",      bus.alu_b,      0);
        chk("rst_alu_op",     bus.alu_op,     0);
        chk("rst_alu_cin",    bus.alu_cin,    0);
        chk("rst_rsp_id",     bus.rsp_id,     0);
        chk("rst_rsp_result", bus.rsp_result, 0);
        chk("rst_rsp_carry",  bus.rsp_carry,  0);
        chk("rst_rsp_err",    bus.rsp_err,    0);
    endtask

    // Presents one request from a negedge; returns on the negedge after its handshake edge.
    task automatic send(input bit port, input logic [5:0] a, input logic [5:0] b,
                        input logic [3:0] op, input logic cin,
                        input logic [5:0] er, input logic ec, input logic ee);
        exp_t e;
        bit   done;
        done    = 0;
        e.id    = port;
        e.res   = er;
        e.carry = ec;
        e.err   = ee;
        if (port) begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_cin = cin; bus.req1_valid = 1'b1;
        end else begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_cin = cin; bus.req0_valid = 1'b1;
        end
        for (int i = 0; i < 60 && !done; i++) begin
            #1;
            if (port ? bus.req1_ready : bus.req0_ready) begin
                chk("other_ready_low", port ? bus.req0_ready : bus.req1_ready, 0);
                sb.push_back(e);
                grant_log.push_back(port);
                done = 1;
            end
            @(negedge clk);
        end
        if (port) bus.req1_valid = 1'b0;
        else      bus.req0_valid = 1'b0;
        if (!done) fail_now("send_timeout");
    endtask

    // One full operation with rsp_ready high: checks EXEC, T+2 latency and return to IDLE.
    task automatic run_op(input bit port, input logic [5:0] a, input logic [5:0] b,
                          input logic [3:0] op, input logic cin,
                          input logic [5:0] er, input logic ec, input logic ee,
                          input logic exp_acin);
        send(port, a, b, op, cin, er, ec, ee);
        chk("exec_busy",      bus.busy,      1);
        chk("exec_rsp_valid", bus.rsp_valid, 0);
        chk("exec_alu_cin",   bus.alu_cin,   exp_acin);
        @(negedge clk);
        chk("resp_rsp_valid", bus.rsp_valid, 1);
        @(negedge clk);
        chk("idle_busy",      bus.busy,      0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (bus.busy || sb.size() != 0); i++) @(negedge clk);
        chk("drain_idle", bus.busy, 0);
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        sb.delete();
        grant_log.delete();
    endtask

    initial begin
        reset          = 1'b1;
        bus.rsp_ready  = 1'b1;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0; bus.req0_cin = 1'b0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0; bus.req1_cin = 1'b0;
        repeat (3) @(negedge clk);

        // reset state, with both valids high to show ready stays low under reset
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk_reset_outputs();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // single ADD from requester 0
        run_op(0, 6'b100111, 6'b010101, 4'b0010, 1'b0, 6'b111100, 1'b0, 1'b0, 1'b0);
        chk("ops_done_1", bus.ops_done, 1);

        // opcode sweep on the same operands
        run_op(0, 6'b100111, 6'b010101, 4'b0000, 1'b0, 6'b000101, 1'b0, 1'b0, 1'b0);
        run_op(0, 6'b100111, 6'b010101, 4'b0001, 1'b0, 6'b110111, 1'b0, 1'b0, 1'b0);
        run_op(0, 6'b100111, 6'b010101, 4'b0110, 1'b0, 6'b010010, 1'b1, 1'b0, 1'b1);
        run_op(0, 6'b100111, 6'b010101, 4'b1100, 1'b0, 6'b001000, 1'b0, 1'b0, 1'b0);

        // carry out of ADD, then illegal opcode from requester 1
        run_op(0, 6'b111111, 6'b000001, 4'b0010, 1'b0, 6'b000000, 1'b1, 1'b0, 1'b0);
        run_op(1, 6'b100111, 6'b010101, 4'b0111, 1'b0, 6'b000000, 1'b0, 1'b1, 1'b0);
        chk("ops_done_7", bus.ops_done, 7);

        // back-pressure: RESP held for five cycles with both requesters waiting
        bus.rsp_ready = 1'b0;
        send(0, 6'b000011, 6'b000101, 4'b0001, 1'b0, 6'b000111, 1'b0, 1'b0);
        @(negedge clk);
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_rsp_valid",  bus.rsp_valid,  1);
            chk("bp_rsp_result", bus.rsp_result, 6'b000111);
            chk("bp_rsp_id",     bus.rsp_id,     0);
            chk("bp_rsp_carry",  bus.rsp_carry,  0);
            chk("bp_rsp_err",    bus.rsp_err,    0);
            chk("bp_req0_ready", bus.req0_ready, 0);
            chk("bp_req1_ready", bus.req1_ready, 0);
            chk("bp_busy",       bus.busy,       1);
            @(negedge clk);
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        @(negedge clk);
        chk("bp_release_idle", bus.busy, 0);
        chk("ops_done_8", bus.ops_done, 8);

        // tie from reset: both requesters continuously valid, grants must alternate
        do_reset();
        fork
            begin
                send(0, 6'b000101, 6'b000011, 4'b0000, 1'b0, 6'b000001, 1'b0, 1'b0);
                send(0, 6'b001010, 6'b000110, 4'b0010, 1'b1, 6'b010001, 1'b0, 1'b0);
            end
            begin
                send(1, 6'b110000, 6'b001100, 4'b0001, 1'b0, 6'b111100, 1'b0, 1'b0);
                send(1, 6'b000001, 6'b000100, 4'b1100, 1'b0, 6'b111010, 1'b0, 1'b0);
            end
        join
        drain();
        chk("tie_grant_count", grant_log.size(), 4);
        if (grant_log.size() == 4) begin
            chk("tie_grant_0", grant_log[0], 0);
            chk("tie_grant_1", grant_log[1], 1);
            chk("tie_grant_2", grant_log[2], 0);
            chk("tie_grant_3", grant_log[3], 1);
        end
        chk("ops_done_tie", bus.ops_done, 4);

        // reset during EXEC of a requester-0 op: op vanishes, requester 0 wins next tie
        send(0, 6'b000001, 6'b000001, 4'b0010, 1'b0, 6'b000010, 1'b0, 1'b0);
        chk("pre_reset_busy", bus.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        #1;
        chk_reset_outputs();
        sb.delete();
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_rsp_after_reset", bus.rsp_valid, 0);
        end
        bus.req0_valid = 1'b1;
        bus.req1_valid = 1'b1;
        #1;
        chk("post_reset_tie_req0", bus.req0_ready, 1);
        chk("post_reset_tie_req1", bus.req1_ready, 0);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        @(negedge clk);

        // 256 operations: counter reaches 255 then wraps to 0
        for (int i = 0; i < 256; i++) begin
            run_op(i[0], 6'b000010, 6'b000011, 4'b0000, 1'b0, 6'b000010, 1'b0, 1'b0, 1'b0);
            if (i == 254) chk("ops_done_255", bus.ops_done, 255);
        end
        chk("ops_done_wrap", bus.ops_done, 0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Two-requester controller that shares one `six_bit_ALU` instance between two independent clients. It arbitrates round-robin between them and registers the chosen operands into the ALU. It then captures the ALU outputs and returns them on a single tagged response channel with a valid/ready handshake. It sits between client logic and the ALU, and is the only driver of the ALU's `a`, `b`, `carry_in` and `ALU_OP` inputs.

## Interface
- No parameters; widths fixed: operands 6 bits, opcode 4 bits.
- `clk` in 1: sole clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `req0_valid`, `req1_valid` in 1: requester has an operation pending.
- `req0_ready`, `req1_ready` out 1: request accepted this cycle when `valid && ready`.
- `req0_a`, `req0_b`, `req1_a`, `req1_b` in 6: operands.
- `req0_op`, `req1_op` in 4: ALU opcode.
- `req0_cin`, `req1_cin` in 1: carry-in.
- `alu_a`, `alu_b` out 6: to ALU `a`, `b`.
- `alu_op` out 4: to ALU `ALU_OP`.
- `alu_cin` out 1: to ALU `carry_in`.
- `alu_result` in 6: from ALU `result`.
- `alu_carry_out` in 1: from ALU `carry_out`.
- `rsp_valid` out 1: response available.
- `rsp_ready` in 1: consumer accepts the response.
- `rsp_id` out 1: requester that issued the operation (0/1).
- `rsp_result` out 6: registered result.
- `rsp_carry` out 1: registered carry.
- `rsp_err` out 1: opcode was illegal.
- `busy` out 1: state != IDLE.
- `ops_done` out 8: count of completed responses; wraps 255→0.

## Operation
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Grant rule: if exactly one `reqN_valid` is high, grant N. If both are high, grant the requester not recorded in `last_id`.
  - `reqN_ready` = (state==IDLE) && grant==N && !reset. The non-granted port sees ready=0.
  - On handshake: latch a, b, op, cin and id into operand registers, set `last_id`=id, go to EXEC.
- EXEC:
  - `alu_*` driven from the operand registers. They are driven from these registers in every state, so the ALU inputs are stable.
  - `alu_cin` = 1 when op==4'b0110 (SUB); otherwise the latched cin.
  - At the clock edge, capture `alu_result` and `alu_carry_out` into the response registers, then go to RESP.
- Legal opcodes: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR.
  - Any other opcode: `rsp_err`=1, `rsp_result`=0, `rsp_carry`=0, same latency.
- RESP:
  - `rsp_valid`=1, with the response registers held stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`: `ops_done` += 1, go to IDLE.
- No request is accepted in EXEC or RESP.

## Timing
- Reset values:
  - state IDLE; `last_id`=1, so requester 0 wins the first tie.
  - Operand registers 0, so `alu_a`/`alu_b`/`alu_op`/`alu_cin` = 0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_carry`=0, `rsp_err`=0, `busy`=0, `ops_done`=0.
  - `req*_ready`=0 while `reset` is high.
- Latency:
  - Handshake in cycle T → EXEC in T+1 → `rsp_valid` high in T+2.
  - With `rsp_ready` held high, `rsp_valid` lasts 1 cycle, IDLE returns in T+3, and the next accept can occur in T+3. Peak throughput: 1 op / 3 cycles.
- Back-pressure: `rsp_ready` low holds RESP indefinitely. All `rsp_*` outputs are constant meanwhile.
- Requests whose valid drops before grant are not remembered. Operands are sampled only on the handshake cycle.
- Reset asserted in any state: in-flight op is discarded, no response is issued, and all registers take their reset values on the next edge.
- `ops_done` increments only on the response handshake and wraps modulo 256.

## Test plan
- Single op, requester 0: a=6'b100111, b=6'b010101, op=0010, cin=0 → accept at T, at T+2 `rsp_valid`=1, `rsp_id`=0, `rsp_result`=6'b111100, `rsp_carry`=0, `ops_done`=1 after handshake.
- Opcode sweep, same operands:
  - 0000 → 6'b000101.
  - 0001 → 6'b110111.
  - 0110 → 6'b010010, with `alu_cin`=1 observed in EXEC.
  - 1100 → 6'b001000.
  - All with `rsp_err`=0.
- Tie and fairness: both valid continuously from reset, each with distinct ops → grants alternate 0,1,0,1. Each port is ready only in its own granted IDLE cycle.
- Back-pressure: hold `rsp_ready`=0 for 5 cycles in RESP → `rsp_*` stable, both `req*_ready`=0, `busy`=1. Release → return to IDLE the next cycle.
- Illegal op 4'b0111 from requester 1 → T+2 `rsp_err`=1, `rsp_result`=0, `rsp_carry`=0, `rsp_id`=1. Carry case: a=6'b111111, b=6'b000001, op=0010 → `rsp_result`=0, `rsp_carry`=1.
- Reset during EXEC → no `rsp_valid` ever appears for that op, all outputs at reset values, and requester 0 wins the next tie. Run 256 ops → `ops_done` wraps to 0.
